// File: rtl/booth2_seq_mul_if.sv
// Request/response bundle for booth2_seq_mul: operand request handshake,
// flush, and result handshake.
interface booth2_seq_mul_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
    logic                      a_signed;
    logic                      b_signed;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*DATA_WIDTH-1:0]   result;

    modport master (
        output flush, in_valid, a, b, a_signed, b_signed, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, a, b, a_signed, b_signed, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/booth2_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth row accumulated per CALC
// cycle over W/2 cycles, W = DATA_WIDTH+2, full 2*DATA_WIDTH-bit product.
module booth2_seq_mul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    booth2_seq_mul_if.slave      bus
);
    localparam int W    = DATA_WIDTH + 2;
    localparam int AW   = 2 * W;
    localparam int ROWS = W / 2;
    localparam int CW   = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            b_prev;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   row;

    logic [2:0]      code;
    logic            neg;
    logic [W:0]      pp;
    logic [AW-1:0]   pp_ext;
    logic [AW-1:0]   inc_ext;
    logic [AW-1:0]   term;
    logic [CW:0]     shamt;

    assign shamt = {row, 1'b0};

    // Booth row select; b_reg is shifted right two bits per row so the
    // current digit always sits in b_reg[1:0], with B[2i-1] kept in b_prev.
    always_comb begin
        code = {b_reg[1], b_reg[0], b_prev};
        neg  = 1'b0;
        pp   = '0;
        case (code)
            3'd1, 3'd2: pp = {a_reg[W-1], a_reg};
            3'd3:       pp = {a_reg, 1'b0};
            3'd4: begin
                pp  = ~{a_reg, 1'b0};
                neg = 1'b1;
            end
            3'd5, 3'd6: begin
                pp  = ~{a_reg[W-1], a_reg};
                neg = 1'b1;
            end
            default:    pp = '0;
        endcase
        pp_ext  = {{(AW-W-1){pp[W]}}, pp};
        inc_ext = {{(AW-1){1'b0}}, neg};
        term    = (pp_ext << shamt) + (inc_ext << shamt);
    end

    // Control FSM and datapath registers; rst beats flush beats handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            b_prev      <= 1'b0;
            acc         <= '0;
            row         <= '0;
        end else if (bus.flush) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.a_signed ? {{2{bus.a[DATA_WIDTH-1]}}, bus.a}
                                                   : {2'b00, bus.a};
                        b_reg      <= bus.b_signed ? {{2{bus.b[DATA_WIDTH-1]}}, bus.b}
                                                   : {2'b00, bus.b};
                        b_prev     <= 1'b0;
                        acc        <= '0;
                        row        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc + term;
                    b_reg  <= b_reg >> 2;
                    b_prev <= b_reg[1];
                    row    <= row + CW'(1);
                    if (row == CW'(ROWS - 1)) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = acc[2*DATA_WIDTH-1:0];
endmodule

// File: tb/tb_booth2_seq_mul.sv
// Directed and random checks for booth2_seq_mul at DATA_WIDTH=32.
module tb_booth2_seq_mul;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    booth2_seq_mul_if #(.DATA_WIDTH(DW)) bus ();

    booth2_seq_mul #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        as;
        logic        bs;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] av, input logic [31:0] bv,
                                            input logic as, input logic bs);
        logic signed [65:0] x;
        logic signed [65:0] y;
        logic signed [65:0] p;
        x = as ? {{34{av[31]}}, av} : {34'd0, av};
        y = bs ? {{34{bv[31]}}, bv} : {34'd0, bv};
        p = x * y;
        return p[63:0];
    endfunction

    // Issue one request from IDLE and wait (bounded) for out_valid.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic as, input logic bs,
                          output logic [63:0] res, output int lat);
        bus.a = av; bus.b = bv; bus.a_signed = as; bus.b_signed = bs;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        bus.a_signed = 1'($urandom); bus.b_signed = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
    endtask

    logic [63:0] res;
    logic [63:0] held;
    int          lat;
    logic        seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        ras;
    logic        rbs;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b0, 64'h000000000000000F};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001};
        vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001};
        vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF00000001};
        vecs[5]  = '{32'h00000000, 32'h12345678, 1'b1, 1'b1, 64'h0000000000000000};
        vecs[6]  = '{32'h00000007, 32'hFFFFFFFD, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFEB};
        vecs[7]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 64'h3FFFFFFF00000001};
        vecs[8]  = '{32'h80000000, 32'h00000002, 1'b0, 1'b0, 64'h0000000100000000};
        vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 64'h8000000080000000};
        vecs[10] = '{32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 64'h8000000080000000};
        vecs[11] = '{32'hFFFFFFFE, 32'h80000000, 1'b1, 1'b0, 64'hFFFFFFFF00000000};

        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.a_signed = 1'b0; bus.b_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", bus.result, 64'd0);
        rst = 1'b0;

        // Directed table; out_ready=1 so each result is taken on the next edge.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
            @(posedge clk); #1;
            check($sformatf("vec%0d_back_idle", i), 64'({bus.in_ready, bus.out_valid}), 64'd2);
        end

        // Backpressure: hold DONE for 10 cycles, then hand off with in_valid
        // already high to show no same-edge re-accept.
        bus.out_ready = 1'b0;
        run_op(32'h0000ABCD, 32'hFFFF0001, 1'b0, 1'b1, res, lat);
        held = res;
        check("bp_result", res, ref_mul(32'h0000ABCD, 32'hFFFF0001, 1'b0, 1'b1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_result", bus.result, held);
            check("bp_hold_flags", 64'({bus.in_ready, bus.out_valid}), 64'd1);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_release_flags", 64'({bus.in_ready, bus.out_valid}), 64'd2);

        // Flush after rows 0..7 have been accumulated (row counter at 8).
        bus.a = 32'd1234; bus.b = 32'd5678; bus.a_signed = 1'b0; bus.b_signed = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_flags", 64'({bus.in_ready, bus.out_valid}), 64'd2);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_no_out_valid", 64'(seen), 64'd0);

        // Flush in IDLE outranks a pending accept.
        bus.flush = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_beats_accept", 64'(bus.in_ready), 64'd1);

        // Reset with row counter at 5, flush also high to confirm rst wins.
        bus.a = 32'hDEADBEEF; bus.b = 32'hCAFEF00D; bus.a_signed = 1'b1; bus.b_signed = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.flush = 1'b0;
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_result", bus.result, 64'd0);
        run_op(32'hFFFFFFF9, 32'h00000006, 1'b1, 1'b1, res, lat);
        check("after_rst_result", res, 64'hFFFFFFFFFFFFFFD6);
        check("after_rst_latency", 64'(lat), 64'd17);
        @(posedge clk); #1;

        // Random regression across all four signedness combinations.
        for (int i = 0; i < 2000; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            ras = 1'(i % 2);
            rbs = 1'((i / 2) % 2);
            if (i % 7 == 0) ra = {ra[31], 31'd0};
            if (i % 11 == 0) rb = ras ? 32'hFFFFFFFF : 32'h80000000;
            run_op(ra, rb, ras, rbs, res, lat);
            if (lat >= 40) check("rand_timeout", 64'(lat), 64'd17);
            else check("rand_result", res, ref_mul(ra, rb, ras, rbs));
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
